// File: rtl/sprite_draw.sv
// sprite_draw: scaled, mirrored, animated sprite renderer with a 2-cycle address->ROM->pixel pipeline
module sprite_draw #(
  parameter int SPR_WIDTH   = 19,
  parameter int SPR_HEIGHT  = 27,
  parameter int WALK_FRAMES = 3,
  parameter int ANIM_DIV    = 6,
  parameter int CORDW       = 16,
  parameter int COLRW       = 4,
  parameter int ADDRW       = 12,
  parameter int TRANS_IDX   = 0
) (
  input  logic                    i_clk_pix,
  input  logic                    i_rst_n,
  input  logic                    i_frame,
  input  logic                    i_line,
  input  logic signed [CORDW-1:0] i_sx,
  input  logic signed [CORDW-1:0] i_sy,
  input  logic signed [CORDW-1:0] i_sprx,
  input  logic signed [CORDW-1:0] i_spry,
  input  logic [4:0]              i_scale_x,
  input  logic [4:0]              i_scale_y,
  input  logic                    i_face_left,
  input  logic                    i_walking,
  input  logic                    i_jumping,
  output logic [ADDRW-1:0]        o_rom_addr,
  input  logic [COLRW-1:0]        i_rom_data,
  output logic [COLRW-1:0]        o_pix,
  output logic                    o_drawing,
  output logic [2:0]              o_anim_frame
);
  localparam int CW = $clog2(SPR_WIDTH + 1);
  localparam int RW = $clog2(SPR_HEIGHT + 1);
  localparam int DW = $clog2(ANIM_DIV + 1);
  localparam int FRAME_SZ = SPR_WIDTH * SPR_HEIGHT;
  localparam logic [CW-1:0] COL_LAST = CW'(SPR_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPR_HEIGHT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);
  localparam logic [2:0] WALK_LAST = 3'(WALK_FRAMES);
  localparam logic [2:0] JUMP_F = 3'(WALK_FRAMES + 1);
  localparam logic [COLRW-1:0] TRANS = COLRW'(TRANS_IDX);

  typedef enum logic [1:0] {IDLE_anim, WALK_anim, JUMP_anim} anim_t;
  typedef enum logic [1:0] {IDLE_line, WAIT_POS, SPR_LINE} line_t;

  anim_t anim_st;
  line_t line_st;
  logic signed [CORDW-1:0] sprx, spry, spry_e;
  logic [4:0] scx, scy, scx_n, scy_n, scy_e, ysub, ys, ysub_n, xsub, cur_xs;
  logic [RW-1:0] row, r, row_n;
  logic [CW-1:0] col, cur_col, col_sel;
  logic [DW-1:0] div;
  logic face, valid, row_act, ra, row_act_n, row_match, adv, ys_wrap;
  logic enter, in_span, x_wrap, last, span_d, opaque;

  // i_frame takes effect before a coincident i_line, so row tracking sees the freshly latched values
  always_comb begin
    scx_n = i_scale_x == 5'd0 ? 5'd1 : i_scale_x;
    scy_n = i_scale_y == 5'd0 ? 5'd1 : i_scale_y;
    spry_e = i_frame ? i_spry : spry;
    scy_e = i_frame ? scy_n : scy;
    ra = i_frame ? 1'b0 : row_act;
    r = i_frame ? '0 : row;
    ys = i_frame ? '0 : ysub;
    row_match = i_line && (i_frame || valid) && i_sy == spry_e;
    adv = i_line && ra && !row_match;
    ys_wrap = ys == scy_e - 5'd1;
    row_act_n = row_match || (ra && !(adv && ys_wrap && r == ROW_LAST));
    row_n = row_match ? '0 : (adv && ys_wrap) ? r + RW'(1) : r;
    ysub_n = row_match ? '0 : adv ? (ys_wrap ? 5'd0 : ys + 5'd1) : ys;
    enter = line_st == WAIT_POS && !i_line && i_sx == sprx;
    in_span = !i_line && (line_st == SPR_LINE || enter);
    cur_col = line_st == SPR_LINE ? col : '0;
    cur_xs = line_st == SPR_LINE ? xsub : 5'd0;
    x_wrap = cur_xs == scx - 5'd1;
    last = x_wrap && cur_col == COL_LAST;
    col_sel = face ? COL_LAST - cur_col : cur_col;
    o_rom_addr = in_span ? ADDRW'(32'(o_anim_frame) * FRAME_SZ + 32'(row) * SPR_WIDTH + 32'(col_sel)) : '0;
    opaque = span_d && i_rom_data != TRANS;
  end

  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      anim_st <= IDLE_anim;
      line_st <= IDLE_line;
      sprx <= '0;
      spry <= '0;
      scx <= '0;
      scy <= '0;
      face <= 1'b0;
      valid <= 1'b0;
      div <= '0;
      row_act <= 1'b0;
      row <= '0;
      ysub <= '0;
      col <= '0;
      xsub <= '0;
      span_d <= 1'b0;
      o_anim_frame <= '0;
      o_drawing <= 1'b0;
      o_pix <= '0;
    end else begin
      if (i_frame) begin
        sprx <= i_sprx;
        spry <= i_spry;
        scx <= scx_n;
        scy <= scy_n;
        face <= i_face_left;
        valid <= 1'b1;
        if (i_jumping) begin
          anim_st <= JUMP_anim;
          o_anim_frame <= JUMP_F;
        end else if (!i_walking) begin
          anim_st <= IDLE_anim;
          o_anim_frame <= '0;
        end else if (anim_st != WALK_anim) begin
          anim_st <= WALK_anim;
          o_anim_frame <= 3'd1;
          div <= '0;
        end else begin
          div <= div == DIV_LAST ? '0 : div + DW'(1);
          if (div == DIV_LAST) o_anim_frame <= o_anim_frame == WALK_LAST ? 3'd1 : o_anim_frame + 3'd1;
        end
      end
      row_act <= row_act_n;
      row <= row_n;
      ysub <= ysub_n;
      line_st <= i_line ? (row_act_n ? WAIT_POS : IDLE_line) : in_span ? (last ? IDLE_line : SPR_LINE) : line_st;
      col <= x_wrap ? cur_col + CW'(1) : cur_col;
      xsub <= x_wrap ? 5'd0 : cur_xs + 5'd1;
      span_d <= in_span;
      o_drawing <= opaque;
      o_pix <= opaque ? i_rom_data : '0;
    end
  end
endmodule

// File: tb/tb_sprite_draw.sv
// tb_sprite_draw: directed checks of sprite placement, scaling, mirroring, transparency, animation and reset
module tb_sprite_draw;
  logic clk, rst_n, frame, line, face, walking, jumping, drawing;
  logic signed [15:0] sx, sy, sprx, spry;
  logic [4:0] scx, scy;
  logic [11:0] rom_addr;
  logic [3:0] rom_data, pix;
  logic [2:0] anim;
  int tests, fails, rom_mode, good, cnt;
  int seq [1:19];
  logic [11:0] addr_l [0:99][0:139];
  logic draw_l [0:99][0:139];
  logic [3:0] pix_l [0:99][0:139];
  int nd [0:99];
  int fd [0:99];

  sprite_draw dut (
    .i_clk_pix(clk), .i_rst_n(rst_n), .i_frame(frame), .i_line(line),
    .i_sx(sx), .i_sy(sy), .i_sprx(sprx), .i_spry(spry),
    .i_scale_x(scx), .i_scale_y(scy), .i_face_left(face),
    .i_walking(walking), .i_jumping(jumping),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data),
    .o_pix(pix), .o_drawing(drawing), .o_anim_frame(anim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous ROM: mode 0 is solid colour 5, mode 1 makes sprite columns 0-2 transparent
  always_ff @(posedge clk)
    rom_data <= rom_mode == 0 ? 4'd5 : ((32'(rom_addr) % 19) < 3) ? 4'd0 : 4'd7;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_line(input int y, input int len, input bit fr, input int rst_at);
    for (int x = 0; x < len; x++) begin
      sx = 16'(x);
      sy = 16'(y);
      line = x == 0;
      frame = fr && x == 0;
      rst_n = x != rst_at;
      @(negedge clk);
      addr_l[y][x] = rom_addr;
      draw_l[y][x] = drawing;
      pix_l[y][x] = pix;
      @(posedge clk);
      #1;
    end
    line = 1'b0;
    frame = 1'b0;
    rst_n = 1'b1;
    nd[y] = 0;
    fd[y] = -1;
    for (int x = 0; x < len; x++)
      if (draw_l[y][x] === 1'b1) begin
        nd[y]++;
        if (fd[y] < 0) fd[y] = x;
      end
  endtask

  task automatic run_frame(input int y0, input int y1);
    run_line(y0, 140, 1'b1, -1);
    for (int y = y0 + 1; y <= y1; y++) run_line(y, 140, 1'b0, -1);
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    @(posedge clk);
    #1;
    frame = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0; fails = 0; rom_mode = 0;
    rst_n = 1'b0; frame = 1'b0; line = 1'b0; sx = '0; sy = '0;
    sprx = 16'sd100; spry = 16'sd50; scx = 5'd1; scy = 5'd0;
    face = 1'b0; walking = 1'b0; jumping = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rom_addr", 32'(rom_addr), 0);
    chk("reset pix", 32'(pix), 0);
    chk("reset drawing", 32'(drawing), 0);
    chk("reset anim_frame", 32'(anim), 0);
    rst_n = 1'b1;

    // sprite at (100,50), scale 1 (scale_y 0 means 1), idle
    run_frame(0, 79);
    good = 0;
    for (int y = 0; y < 80; y++)
      if (nd[y] == ((y >= 50 && y <= 76) ? 19 : 0) && (nd[y] == 0 || fd[y] == 102)) good++;
    chk("scale1 line spans", good, 80);
    chk("scale1 first row count", nd[50], 19);
    chk("scale1 first draw x", fd[50], 102);
    chk("scale1 last row 76", nd[76], 19);
    chk("scale1 line 77 empty", nd[77], 0);
    cnt = 0;
    for (int k = 0; k < 19; k++) if (addr_l[50][100 + k] == 12'(k)) cnt++;
    chk("scale1 addr 0..18", cnt, 19);
    chk("scale1 row10 addr", 32'(addr_l[60][100]), 190);
    chk("scale1 pix", 32'(pix_l[50][102]), 5);

    // scale 2x3 at (10,5)
    sprx = 16'sd10; spry = 16'sd5; scx = 5'd2; scy = 5'd3;
    run_frame(0, 90);
    good = 0;
    for (int y = 0; y <= 90; y++)
      if (nd[y] == ((y >= 5 && y <= 85) ? 38 : 0) && (nd[y] == 0 || fd[y] == 12)) good++;
    chk("scale2x3 line spans", good, 91);
    chk("scale2x3 col0 held", 32'(addr_l[5][11]), 0);
    chk("scale2x3 col1 start", 32'(addr_l[5][12]), 1);
    chk("scale2x3 col18 end", 32'(addr_l[5][47]), 18);
    chk("scale2x3 line7 row0", 32'(addr_l[7][10]), 0);
    chk("scale2x3 line8 row1", 32'(addr_l[8][10]), 19);
    chk("scale2x3 line85 row26", 32'(addr_l[85][10]), 494);

    // mirrored
    sprx = 16'sd100; spry = 16'sd50; scx = 5'd1; scy = 5'd1; face = 1'b1;
    run_frame(48, 50);
    cnt = 0;
    for (int k = 0; k < 19; k++) if (addr_l[50][100 + k] == 12'(18 - k)) cnt++;
    chk("face_left addr 18..0", cnt, 19);

    // i_line mid-span aborts it
    face = 1'b0;
    run_line(49, 140, 1'b1, -1);
    run_line(50, 110, 1'b0, -1);
    run_line(51, 140, 1'b0, -1);
    chk("abort no carry addr", 32'(addr_l[51][1]), 0);
    chk("abort next row addr", 32'(addr_l[51][100]), 19);
    chk("abort next row draws", 32'(draw_l[51][102]), 1);

    // sprite never matched
    spry = -16'sd200;
    run_frame(0, 79);
    cnt = 0;
    for (int y = 0; y < 80; y++) cnt += nd[y];
    chk("offscreen no draw", cnt, 0);

    // frame and line together on the sprite's top line, transparent columns 0-2
    spry = 16'sd50; rom_mode = 1;
    run_line(50, 140, 1'b1, -1);
    chk("trans draw count", nd[50], 16);
    chk("trans first draw", fd[50], 105);
    chk("trans col2 drawing", 32'(draw_l[50][104]), 0);
    chk("trans col1 pix", 32'(pix_l[50][103]), 0);
    chk("opaque pix", 32'(pix_l[50][105]), 7);
    rom_mode = 0;

    // reset mid-span
    run_line(49, 140, 1'b1, -1);
    run_line(50, 140, 1'b0, -1);
    run_line(51, 140, 1'b0, 105);
    for (int y = 52; y <= 60; y++) run_line(y, 140, 1'b0, -1);
    chk("pre-reset drawing", 32'(draw_l[51][105]), 1);
    chk("post-reset drawing", 32'(draw_l[51][106]), 0);
    chk("post-reset addr", 32'(addr_l[51][106]), 0);
    cnt = 0;
    for (int x = 106; x < 140; x++) cnt += int'(draw_l[51][x]);
    for (int y = 52; y <= 60; y++) cnt += nd[y];
    chk("post-reset silent", cnt, 0);

    // walk animation
    walking = 1'b1;
    run_line(49, 140, 1'b1, -1);
    seq[1] = 32'(anim);
    run_line(50, 140, 1'b0, -1);
    chk("walk frame1 addr", 32'(addr_l[50][100]), 513);
    for (int k = 2; k <= 19; k++) begin
      pulse_frame();
      seq[k] = 32'(anim);
    end
    cnt = 0;
    for (int k = 1; k <= 19; k++) if (seq[k] == 1 + ((k - 1) / 6) % 3) cnt++;
    chk("walk sequence", cnt, 19);
    chk("walk k6", seq[6], 1);
    chk("walk k7", seq[7], 2);
    chk("walk k13", seq[13], 3);
    chk("walk k19 wrap", seq[19], 1);
    jumping = 1'b1;
    pulse_frame();
    chk("jump frame", 32'(anim), 4);
    walking = 1'b0; jumping = 1'b0;
    pulse_frame();
    chk("idle frame", 32'(anim), 0);
    walking = 1'b1; jumping = 1'b1;
    pulse_frame();
    chk("jump priority", 32'(anim), 4);
    jumping = 1'b0;
    pulse_frame();
    chk("walk re-entry", 32'(anim), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sprite_draw.md
SPRITE_DRAW -- requirements
Module: sprite_draw

Interface
REQ-001 Parameters SHALL be: SPR_WIDTH 19 (pixels per sprite row); SPR_HEIGHT 27 (rows per sprite); WALK_FRAMES 3 (walk animation frames); ANIM_DIV 6 (video frames per walk step); CORDW 16 (signed coordinate width); COLRW 4 (colour-index width); ADDRW 12 (ROM address width); TRANS_IDX 0 (transparent colour index).
REQ-002 Clock and reset SHALL be: i_clk_pix in 1 (pixel clock; sole clock); i_rst_n in 1 (reset; synchronous, active-low).
REQ-003 Timing inputs SHALL be: i_frame in 1 (one-cycle pulse at frame start); i_line in 1 (one-cycle pulse at the start of every line, blanking included); i_sx in CORDW signed (current screen x); i_sy in CORDW signed (current screen y).
REQ-004 Sprite state inputs from sprite_position SHALL be: i_sprx, i_spry in CORDW signed (top-left); i_scale_x, i_scale_y in 5 (integer scale); i_face_left, i_walking, i_jumping in 1 each.
REQ-005 ROM ports SHALL be: o_rom_addr out ADDRW (pixel address); i_rom_data in COLRW (colour index, valid exactly 1 cycle after address).
REQ-006 Outputs SHALL be: o_pix out COLRW (colour index); o_drawing out 1 (opaque sprite pixel present); o_anim_frame out 3 (current animation frame).

Function
REQ-007 On i_frame the block SHALL latch sprx, spry, scale_x, scale_y (0 treated as 1) and face_left; these hold for the whole frame.
REQ-008 Animation FSM states SHALL be IDLE_anim (frame 0), WALK_anim (frames 1..WALK_FRAMES), JUMP_anim (frame WALK_FRAMES+1), evaluated only on i_frame.
REQ-009 Transition priority SHALL be: i_jumping -> JUMP_anim; else i_walking -> WALK_anim; else IDLE_anim.
REQ-010 Entering WALK_anim SHALL set frame 1 and the divider to 0; in WALK_anim the divider SHALL increment per i_frame and on reaching ANIM_DIV-1 wrap to 0 and advance the frame, WALK_FRAMES wrapping to 1.
REQ-011 Line FSM states SHALL be IDLE_line, WAIT_POS, SPR_LINE: on i_line with row-active set, IDLE_line -> WAIT_POS; WAIT_POS -> SPR_LINE in the cycle i_sx == latched sprx; SPR_LINE -> IDLE_line after SPR_WIDTH*scale_x pixel cycles.
REQ-012 Row tracking SHALL be: on i_frame clear row, y-subcount and row-active; on i_line with i_sy == latched spry set row-active, row 0; on each subsequent i_line advance the y-subcount, wrapping at scale_y-1 to row+1; after row SPR_HEIGHT-1 completes, clear row-active.
REQ-013 If latched spry is never matched (sprite above first i_sy, or below last), nothing SHALL be drawn that frame; same per line for unmatched sprx.
REQ-014 In SPR_LINE, each column SHALL repeat for scale_x cycles; column select SHALL be (SPR_WIDTH-1-col) when face_left else col.
REQ-015 o_rom_addr SHALL equal frame*SPR_WIDTH*SPR_HEIGHT + row*SPR_WIDTH + column select, modulo 2^ADDRW.
REQ-016 Latency SHALL be exactly 2 cycles: o_pix/o_drawing for the i_sx of a cycle appear 2 cycles later (address, ROM, output register).
REQ-017 o_drawing SHALL be 1 only for in-span pixels with i_rom_data != TRANS_IDX; o_pix SHALL be i_rom_data when o_drawing else 0.
REQ-018 i_frame and i_line in the same cycle: the frame latch SHALL take effect first and the line SHALL be evaluated against the new values.
REQ-019 An i_line arriving while in SPR_LINE SHALL abort the span and be processed as a new line.

Reset
REQ-020 While i_rst_n is 0 at a clock edge, both FSMs SHALL go idle, all counters and latches clear, and o_rom_addr, o_pix, o_drawing, o_anim_frame SHALL be 0 from the next cycle.
REQ-021 Reset mid-span SHALL abort drawing; no o_drawing pulse SHALL follow reset until a new frame latch and row match.

Verification
REQ-022 Sprite (100,50), scale 1, idle, ROM data 5 -> o_drawing high for 19 cycles starting 2 cycles after i_sx==100 on lines 50..76; o_rom_addr 0..18 on line 50.
REQ-023 Scale 2x3, sprx 10 -> each column held 2 cycles (38-cycle span), each row repeated on 3 lines (81 lines); row 1 first appears on line spry+3.
REQ-024 face_left=1, row 0, frame 0 -> o_rom_addr sequence 18,17,...,0.
REQ-025 i_walking held 19 frames -> o_anim_frame 1,2,3,1 with changes every 6 frames; i_jumping asserted -> 4 on next i_frame; both released -> 0.
REQ-026 ROM returns TRANS_IDX on columns 0-2 -> o_drawing 0, o_pix 0 for those 3 pixels, 1 thereafter.
REQ-027 spry=-200 (below first i_sy) -> no o_drawing all frame; reset asserted mid-span -> o_drawing 0 next cycle and stays 0 through the rest of that frame.
